// File: rtl/axi_wr_subordinate_if.sv
// AXI4 write-channel bundle (AW, W, B) between a manager and a subordinate.
interface axi_wr_subordinate_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic                awvalid_i;
  logic                awready_o;
  logic [ID_W-1:0]     awid_i;
  logic [ADDR_W-1:0]   awaddr_i;
  logic [7:0]          awlen_i;
  logic [2:0]          awsize_i;
  logic [1:0]          awburst_i;
  logic                wvalid_i;
  logic                wready_o;
  logic [DATA_W-1:0]   wdata_i;
  logic [DATA_W/8-1:0] wstrb_i;
  logic                wlast_i;
  logic                bvalid_o;
  logic                bready_i;
  logic [ID_W-1:0]     bid_o;
  logic [1:0]          bresp_o;

  modport master (
    output awvalid_i, awid_i, awaddr_i, awlen_i, awsize_i, awburst_i,
    output wvalid_i, wdata_i, wstrb_i, wlast_i, bready_i,
    input  awready_o, wready_o, bvalid_o, bid_o, bresp_o
  );

  modport slave (
    input  awvalid_i, awid_i, awaddr_i, awlen_i, awsize_i, awburst_i,
    input  wvalid_i, wdata_i, wstrb_i, wlast_i, bready_i,
    output awready_o, wready_o, bvalid_o, bid_o, bresp_o
  );
endinterface

// File: rtl/axi_wr_subordinate.sv
// AXI4 write subordinate: one burst in flight, FIXED/INCR/WRAP addressing,
// strobed writes into a word memory, one B response per burst.
module axi_wr_subordinate #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  axi_wr_subordinate_if.slave          bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]            dbg_data_o
);
  localparam int     NB        = DATA_W / 8;
  localparam int     BL        = $clog2(NB);
  localparam int     IW        = $clog2(MEM_DEPTH);
  localparam longint MEM_BYTES = longint'(MEM_DEPTH) * NB;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   id_q, bid_q;
  logic [ADDR_W-1:0] a0_q;
  logic [7:0]        len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q, bresp_q;
  logic              illegal_q, slv_q, dec_q, over_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              aw_fire, w_fire, b_fire;
  logic [ADDR_W-1:0] aw_b, aw_end;
  logic              aw_illegal;
  logic [ADDR_W-1:0] bb, n_off, span, base, baddr;
  logic              in_rng, we, dec_beat, slv_beat;
  logic [IW-1:0]     widx;

  assign aw_fire = bus.awvalid_i && bus.awready_o;
  assign w_fire  = bus.wvalid_i && bus.wready_o;
  assign b_fire  = bus.bvalid_o && bus.bready_i;

  // Burst legality, judged once on the incoming AW
  always_comb begin
    aw_b       = ADDR_W'(1) << bus.awsize_i;
    aw_end     = (bus.awaddr_i & ~(aw_b - 1)) + ((ADDR_W'(bus.awlen_i) + 1) << bus.awsize_i) - 1;
    aw_illegal = 1'b0;
    if (bus.awburst_i == 2'b11) aw_illegal = 1'b1;
    if (32'(bus.awsize_i) > BL) aw_illegal = 1'b1;
    if (bus.awburst_i == 2'b10) begin
      if (!(bus.awlen_i inside {8'd1, 8'd3, 8'd7, 8'd15})) aw_illegal = 1'b1;
      if ((bus.awaddr_i & (aw_b - 1)) != '0) aw_illegal = 1'b1;
    end
    if (bus.awburst_i == 2'b01 && (aw_end >> 12) != (bus.awaddr_i >> 12)) aw_illegal = 1'b1;
  end

  // Current beat address and its write/error qualifiers
  always_comb begin
    bb    = ADDR_W'(1) << size_q;
    n_off = ADDR_W'(cnt_q) << size_q;
    span  = (ADDR_W'(len_q) + 1) << size_q;
    base  = a0_q & ~(span - 1);
    case (burst_q)
      2'b00:   baddr = a0_q;
      2'b10:   baddr = base + ((a0_q - base + n_off) & (span - 1));
      default: baddr = (cnt_q == 8'd0) ? a0_q : (a0_q & ~(bb - 1)) + n_off;
    endcase
    in_rng   = 64'(baddr) < 64'(MEM_BYTES);
    widx     = IW'(baddr >> BL);
    // beats past len (missing wlast) are absorbed without writing
    we       = w_fire && !illegal_q && !over_q && in_rng && !rst_i;
    dec_beat = w_fire && !illegal_q && !over_q && !in_rng;
    slv_beat = w_fire && !over_q && (bus.wlast_i != (cnt_q == len_q));
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aw_fire) state_nx = DATA;
      DATA:    if (w_fire && bus.wlast_i) state_nx = RESP;
      RESP:    if (b_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs; B fields come from registers so they hold while bvalid waits
  always_comb begin
    bus.awready_o = (state == IDLE);
    bus.wready_o  = (state == DATA);
    bus.bvalid_o  = (state == RESP);
    bus.bid_o     = bid_q;
    bus.bresp_o   = bresp_q;
  end

  // Burst context, beat counter, error accumulation and B capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bid_q   <= '0;
      bresp_q <= 2'b00;
    end else begin
      if (aw_fire) begin
        id_q      <= bus.awid_i;
        a0_q      <= bus.awaddr_i;
        len_q     <= bus.awlen_i;
        size_q    <= bus.awsize_i;
        burst_q   <= bus.awburst_i;
        illegal_q <= aw_illegal;
        cnt_q     <= 8'd0;
        slv_q     <= 1'b0;
        dec_q     <= 1'b0;
        over_q    <= 1'b0;
      end
      if (w_fire) begin
        if (!over_q) cnt_q <= cnt_q + 8'd1;
        if (!over_q && cnt_q == len_q && !bus.wlast_i) over_q <= 1'b1;
        if (slv_beat) slv_q <= 1'b1;
        if (dec_beat) dec_q <= 1'b1;
        if (bus.wlast_i) begin
          bid_q <= id_q;
          if (dec_q || dec_beat)                   bresp_q <= 2'b11;
          else if (slv_q || slv_beat || illegal_q) bresp_q <= 2'b10;
          else                                     bresp_q <= 2'b00;
        end
      end
    end
  end

  // Strobed byte writes into the word memory (contents survive reset)
  always_ff @(posedge clk_i) begin
    if (we)
      for (int i = 0; i < NB; i++)
        if (bus.wstrb_i[i]) mem[widx][8*i +: 8] <= bus.wdata_i[8*i +: 8];
  end

  assign dbg_data_o = mem[dbg_addr_i];
endmodule
